// File: rtl/ascii7seg_buffer_pkg.sv
// rtl/ascii7seg_buffer_pkg.sv - shared constants, FSM encoding and segment lookup helpers
package ascii7seg_buffer_pkg;

  localparam logic [6:0] ASC_BS    = 7'h08;
  localparam logic [6:0] ASC_CR    = 7'h0D;
  localparam logic [6:0] ASC_SPACE = 7'h20;
  localparam logic [6:0] ASC_ZERO  = 7'h30;
  localparam logic [6:0] ASC_DASH  = 7'h2D;
  localparam logic [6:0] ASC_UNDER = 7'h5F;
  localparam logic [6:0] ASC_DEL   = 7'h7F;

  // Segment patterns are stored active-low (0 = segment lit), bit 6 = seg 6.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0001110;
  localparam logic [6:0] SEG_UNDER = 7'b1110111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Pattern for a supported character; unsupported codes fall through to blank.
  function automatic logic [6:0] seg_table(input logic [6:0] ch);
    case (ch)
      7'h30:        seg_table = 7'b1000000;
      7'h31:        seg_table = 7'b1111001;
      7'h32:        seg_table = 7'b0100100;
      7'h33:        seg_table = 7'b0110000;
      7'h34:        seg_table = 7'b0011001;
      7'h35:        seg_table = 7'b0010010;
      7'h36:        seg_table = 7'b0000010;
      7'h37:        seg_table = 7'b1111000;
      7'h38:        seg_table = 7'b0000000;
      7'h39:        seg_table = 7'b0010000;
      7'h41, 7'h61: seg_table = 7'b0001000;
      7'h42, 7'h62: seg_table = 7'b0000011;
      7'h43, 7'h63: seg_table = 7'b1000110;
      7'h44, 7'h64: seg_table = 7'b0100001;
      7'h45, 7'h65: seg_table = 7'b0000110;
      7'h46, 7'h66: seg_table = 7'b0001110;
      ASC_DASH:     seg_table = SEG_DASH;
      ASC_UNDER:    seg_table = SEG_UNDER;
      default:      seg_table = SEG_BLANK;
    endcase
  endfunction

  // True for the characters the display can render: digits, hex letters, space, '-', '_'.
  function automatic logic char_supported(input logic [6:0] ch);
    char_supported = (ch >= ASC_ZERO && ch <= ASC_ZERO + 7'd9) ||
                     (ch >= 7'h41 && ch <= 7'h46) ||
                     (ch >= 7'h61 && ch <= 7'h66) ||
                     (ch == ASC_SPACE) || (ch == ASC_DASH) || (ch == ASC_UNDER);
  endfunction

endpackage

// File: rtl/ascii7seg_buffer_if.sv
// rtl/ascii7seg_buffer_if.sv - character stream handshake between producer and display buffer
interface ascii7seg_buffer_if;
  logic       char_valid;
  logic       char_ready;
  logic [6:0] char_data;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/ascii7seg_buffer_decode.sv
// rtl/ascii7seg_buffer_decode.sv - combinational ASCII to active-low 7-segment decoder
module ascii_seg_decode
  import ascii7seg_buffer_pkg::*;
(
  input  logic [6:0] ch_i,
  output logic [6:0] seg_o,
  output logic       unsupported_o
);

  assign seg_o         = seg_table(ch_i);
  assign unsupported_o = ~char_supported(ch_i);

endmodule

// File: rtl/ascii7seg_buffer.sv
// rtl/ascii7seg_buffer.sv - N-digit ASCII shift buffer driving 7-segment displays
module ascii7seg_buffer
  import ascii7seg_buffer_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  ascii7seg_buffer_if.slave                 chr,
  input  logic                              clear,
  input  logic                              blink_en,
  output logic [7*NUM_DIGITS-1:0]           display,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              error
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] POL = {7{~ACTIVE_LOW}};

  state_e                        state_q, state_d;
  logic                          ready_q;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0][6:0]    buf_q, buf_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          error_q, error_d;
  logic [BW-1:0]                 blink_cnt_q;
  logic                          phase_q;
  logic [NUM_DIGITS-1:0][6:0]    disp_q, disp_d;
  logic [NUM_DIGITS-1:0][6:0]    dec_seg;
  logic [NUM_DIGITS-1:0]         dec_unsup;
  logic                          accept;
  logic [6:0]                    ch;

  assign ch             = chr.char_data;
  assign accept         = chr.char_valid & ready_q;
  assign chr.char_ready = ready_q;
  assign display        = disp_q;
  assign count          = count_q;
  assign error          = error_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    ascii_seg_decode u_dec (
      .ch_i          (buf_q[g]),
      .seg_o         (dec_seg[g]),
      .unsupported_o (dec_unsup[g])
    );
  end

  // Next state: character handling in IDLE, one-digit-per-cycle blanking sweep in CLEAR.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        // clear has priority; a char accepted on the same edge is consumed and dropped
        if (clear || (accept && ch == ASC_CR)) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          count_d = '0;
          error_d = 1'b0;
        end else if (accept) begin
          if (ch == ASC_BS) begin
            if (count_q != '0) begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) buf_d[i] = buf_q[i+1];
              buf_d[NUM_DIGITS-1] = ASC_SPACE;
              count_d = count_q - CW'(1);
            end
          end else if (ch < ASC_SPACE || ch == ASC_DEL) begin
            error_d = 1'b1;
          end else begin
            for (int i = 1; i < NUM_DIGITS; i++) buf_d[i] = buf_q[i-1];
            buf_d[0] = ch;
            if (count_q != CW'(NUM_DIGITS)) count_d = count_q + CW'(1);
            if (!char_supported(ch)) error_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        buf_d[idx_q] = ASC_SPACE;
        if (idx_q == IW'(NUM_DIGITS - 1)) state_d = ST_IDLE;
        else                              idx_d   = idx_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, buffer and status registers; ready is registered so it stays low through reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      buf_q   <= {NUM_DIGITS{ASC_SPACE}};
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Blink timebase: phase flips each BLINK_DIV cycles, held on while blinking is disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Output pattern per digit: unsupported chars show as 'F', off phase blanks everything.
  always_comb begin
    disp_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      disp_d[i] = (phase_q ? (dec_unsup[i] ? SEG_ERR : dec_seg[i]) : SEG_BLANK) ^ POL;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) disp_q <= {NUM_DIGITS{SEG_BLANK ^ POL}};
    else          disp_q <= disp_d;
  end

endmodule
